// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, last-served encoding, arbitration helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_BUSY  = 2'd1,
        ST_STORE_BUSY = 2'd2
    } dmem_state_t;

    typedef enum logic {
        SERVED_LOAD  = 1'b0,
        SERVED_STORE = 1'b1
    } served_t;

    // Loads always touch the whole word.
    localparam logic [3:0] LOAD_BYTE_ENABLE = 4'hF;

    // A lone requester wins; on a tie the side that was not served last wins.
    function automatic logic load_wins(input logic load_req,
                                       input logic store_req,
                                       input served_t last);
        return load_req && (!store_req || (last == SERVED_STORE));
    endfunction

endpackage

// File: rtl/dmem_timeout_counter.sv
// Wait-cycle counter for one memory transaction; terminal flags that the next enabled count hits the limit.
// Latency: count updates one cycle after enable; terminal is combinational from the count register.
// Backpressure: none; clear has priority over enable.
module dmem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    // TIMEOUT_CYCLES is limited to 1..255, so eight bits always suffice.
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    // Count BUSY cycles that passed without mem_ready.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // High when one more cycle without mem_ready reaches TIMEOUT_CYCLES.
    assign terminal = (count == LAST_COUNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the load and store units onto a single data-memory port with timeout abort.
// Latency: grant one cycle after the request is sampled; done one cycle after mem_ready (2 cycles minimum).
// Backpressure: requests are held off while a transaction is in flight; mem_ready stalls, timeout aborts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  load_request,
    input  logic [ADDR_WIDTH-1:0] load_address,
    output logic                  load_grant,
    output logic                  load_done,
    output logic [DATA_WIDTH-1:0] load_data,

    input  logic                  store_request,
    input  logic [ADDR_WIDTH-1:0] store_address,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [3:0]            store_byte_enable,
    output logic                  store_grant,
    output logic                  store_done,

    output logic                  mem_valid,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [3:0]            mem_byte_enable,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_read_data,

    output logic                  error
);

    dmem_state_t           state_q, state_d;
    served_t               last_q, last_d;

    logic                  load_grant_d, store_grant_d;
    logic                  load_done_d, store_done_d, error_d;
    logic [DATA_WIDTH-1:0] load_data_d;
    logic                  mem_valid_d, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_address_d;
    logic [DATA_WIDTH-1:0] mem_write_data_d;
    logic [3:0]            mem_byte_enable_d;

    logic                  busy;
    logic                  busy_is_load;
    logic                  timeout_hit;

    assign busy         = (state_q != ST_IDLE);
    assign busy_is_load = (state_q == ST_LOAD_BUSY);

    // Counter restarts every IDLE cycle so it reads zero on entry to BUSY.
    dmem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (!busy),
        .enable   (busy && !mem_ready),
        .terminal (timeout_hit)
    );

    // Next state and next value of every registered output.
    always_comb begin
        state_d           = state_q;
        last_d            = last_q;
        load_grant_d      = 1'b0;
        store_grant_d     = 1'b0;
        load_done_d       = 1'b0;
        store_done_d      = 1'b0;
        error_d           = 1'b0;
        load_data_d       = load_data;
        mem_valid_d       = mem_valid;
        mem_write_d       = mem_write;
        mem_address_d     = mem_address;
        mem_write_data_d  = mem_write_data;
        mem_byte_enable_d = mem_byte_enable;

        unique case (state_q)
            ST_IDLE: begin
                // mem_ready is ignored here: nothing is outstanding.
                if (load_wins(load_request, store_request, last_q)) begin
                    state_d           = ST_LOAD_BUSY;
                    load_grant_d      = 1'b1;
                    mem_valid_d       = 1'b1;
                    mem_write_d       = 1'b0;
                    mem_address_d     = load_address;
                    mem_write_data_d  = '0;
                    mem_byte_enable_d = LOAD_BYTE_ENABLE;
                end else if (store_request) begin
                    state_d           = ST_STORE_BUSY;
                    store_grant_d     = 1'b1;
                    mem_valid_d       = 1'b1;
                    mem_write_d       = 1'b1;
                    mem_address_d     = store_address;
                    mem_write_data_d  = store_data;
                    mem_byte_enable_d = store_byte_enable;
                end
            end
            ST_LOAD_BUSY, ST_STORE_BUSY: begin
                // mem_ready beats a timeout landing on the same edge.
                if (mem_ready || timeout_hit) begin
                    state_d      = ST_IDLE;
                    mem_valid_d  = 1'b0;
                    error_d      = !mem_ready;
                    load_done_d  = busy_is_load;
                    store_done_d = !busy_is_load;
                    last_d       = busy_is_load ? SERVED_LOAD : SERVED_STORE;
                    if (busy_is_load) begin
                        load_data_d = mem_ready ? mem_read_data : '0;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // State, arbitration history and all outputs are registered together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            last_q          <= SERVED_STORE;
            load_grant      <= 1'b0;
            store_grant     <= 1'b0;
            load_done       <= 1'b0;
            store_done      <= 1'b0;
            error           <= 1'b0;
            load_data       <= '0;
            mem_valid       <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_write_data  <= '0;
            mem_byte_enable <= 4'h0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            load_grant      <= load_grant_d;
            store_grant     <= store_grant_d;
            load_done       <= load_done_d;
            store_done      <= store_done_d;
            error           <= error_d;
            load_data       <= load_data_d;
            mem_valid       <= mem_valid_d;
            mem_write       <= mem_write_d;
            mem_address     <= mem_address_d;
            mem_write_data  <= mem_write_data_d;
            mem_byte_enable <= mem_byte_enable_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a transaction-level reference model.
// Latency: n/a (testbench).
// Backpressure: the memory responder applies per-transaction wait latencies, including timeouts.
module tb_dmem_arbiter;

    localparam int TO = 15;

    typedef struct {
        bit          is_load;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          lat;    // BUSY cycles before mem_ready is driven high
    } op_t;

    typedef struct {
        op_t         op;
        bit          err;
        logic [31:0] ld;     // load_data expected after this transaction
        bit          b2b;    // accepted in the done cycle of the previous one
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_request, store_request;
    logic [31:0] load_address, store_address, store_data;
    logic [3:0]  store_byte_enable;
    logic        load_grant, load_done, store_grant, store_done;
    logic [31:0] load_data;
    logic        mem_valid, mem_write, mem_ready, error;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [3:0]  mem_byte_enable;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;

    op_t  lops[$], sops[$], resp_q[$];
    exp_t exp_q[$];

    bit          model_last_load = 1'b0;
    logic [31:0] model_ld = '0;

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .load_request      (load_request),
        .load_address      (load_address),
        .load_grant        (load_grant),
        .load_done         (load_done),
        .load_data         (load_data),
        .store_request     (store_request),
        .store_address     (store_address),
        .store_data        (store_data),
        .store_byte_enable (store_byte_enable),
        .store_grant       (store_grant),
        .store_done        (store_done),
        .mem_valid         (mem_valid),
        .mem_write         (mem_write),
        .mem_address       (mem_address),
        .mem_write_data    (mem_write_data),
        .mem_byte_enable   (mem_byte_enable),
        .mem_ready         (mem_ready),
        .mem_read_data     (mem_read_data),
        .error             (error)
    );

    function automatic op_t mk_op(bit is_load, logic [31:0] addr, logic [31:0] wdata,
                                  logic [3:0] be, logic [31:0] rdata, int lat);
        op_t o;
        o.is_load = is_load; o.addr = addr; o.wdata = wdata;
        o.be = be; o.rdata = rdata; o.lat = lat;
        return o;
    endfunction

    function automatic int pick_lat();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return int'($urandom_range(1, 4));
            2:       return int'($urandom_range(TO - 2, TO + 1));
            default: return int'($urandom_range(0, TO + 5));
        endcase
    endfunction

    // Reference model: fair alternation while both sides have work, then drain the rest.
    task automatic model_round();
        int li = 0;
        int si = 0;
        int n = 0;
        bit take_load;
        exp_t e;
        while (li < lops.size() || si < sops.size()) begin
            take_load = (li < lops.size()) && (si >= sops.size() || !model_last_load);
            e.op  = take_load ? lops[li] : sops[si];
            if (take_load) li++; else si++;
            e.err = (e.op.lat >= TO);
            if (e.op.is_load) model_ld = e.err ? 32'h0 : e.op.rdata;
            e.ld  = model_ld;
            e.b2b = (n > 0);
            model_last_load = take_load;
            exp_q.push_back(e);
            resp_q.push_back(e.op);
            n++;
        end
    endtask

    task automatic drive_load();
        int c;
        for (int i = 0; i < lops.size(); i++) begin
            load_request = 1'b1;
            load_address = lops[i].addr;
            c = 0;
            do begin @(negedge clock); c++; end while (!load_grant && c < 400);
            if (!load_grant) begin
                tests++; fails++;
                $display("FAIL load_grant_wait got no grant after %0d cycles, want grant", c);
                break;
            end
        end
        load_request = 1'b0;
        load_address = $urandom;
    endtask

    task automatic drive_store();
        int c;
        for (int i = 0; i < sops.size(); i++) begin
            store_request     = 1'b1;
            store_address     = sops[i].addr;
            store_data        = sops[i].wdata;
            store_byte_enable = sops[i].be;
            c = 0;
            do begin @(negedge clock); c++; end while (!store_grant && c < 400);
            if (!store_grant) begin
                tests++; fails++;
                $display("FAIL store_grant_wait got no grant after %0d cycles, want grant", c);
                break;
            end
        end
        store_request     = 1'b0;
        store_address     = $urandom;
        store_data        = $urandom;
        store_byte_enable = 4'($urandom);
    endtask

    task automatic run_round();
        int target;
        int c = 0;
        model_round();
        target = done_seen + lops.size() + sops.size();
        fork
            drive_load();
            drive_store();
        join
        while (done_seen < target && c < 200) begin @(negedge clock); c++; end
        tests++;
        if (done_seen < target) begin
            fails++;
            $display("FAIL round_done_wait got %0d completions, want %0d", done_seen, target);
        end
        repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({load_grant, load_done, load_data, store_grant, store_done, mem_valid, mem_write,
             mem_address, mem_write_data, mem_byte_enable, error} != '0) begin
            fails++;
            $display("FAIL %s got lg=%0b ld=%0b ldata=%h sg=%0b sd=%0b mv=%0b mw=%0b ma=%h mwd=%h be=%h err=%0b, want all zero",
                     name, load_grant, load_done, load_data, store_grant, store_done, mem_valid,
                     mem_write, mem_address, mem_write_data, mem_byte_enable, error);
        end
    endtask

    // Memory responder: junk mem_ready while idle, scripted latency while a request is outstanding.
    initial begin
        op_t r;
        int  k;
        bit  in_txn;
        mem_ready = 1'b0; mem_read_data = '0; in_txn = 1'b0; k = 0;
        r = mk_op(1'b0, '0, '0, '0, '0, 1000);
        forever begin
            @(negedge clock);
            if (reset || !mem_valid) begin
                in_txn        = 1'b0;
                mem_ready     = ($urandom_range(0, 3) == 0);
                mem_read_data = $urandom;
            end else begin
                if (!in_txn) begin
                    in_txn = 1'b1; k = 0;
                    if (resp_q.size() > 0) r = resp_q.pop_front();
                    else r.lat = 1000;
                end else begin
                    k++;
                end
                mem_ready     = (k == r.lat);
                mem_read_data = (k == r.lat) ? r.rdata : $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard on each grant and checks the port and completion against it.
    exp_t cur;
    bit   active = 1'b0;
    int   vcnt = 0;
    int   cyc = 0;
    int   last_done_cyc = -100;
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            active = 1'b0;
        end else begin
            if (load_grant || store_grant) begin
                tests++;
                if (exp_q.size() == 0 || (load_grant && store_grant)) begin
                    fails++;
                    $display("FAIL grant_expected got lg=%0b sg=%0b with %0d pending, want one grant", load_grant, store_grant, exp_q.size());
                end else begin
                    cur = exp_q.pop_front();
                    active = 1'b1; vcnt = 0;
                    if (load_grant != cur.op.is_load) begin
                        fails++;
                        $display("FAIL grant_order got load_grant=%0b, want %0b", load_grant, cur.op.is_load);
                    end
                    if (cur.b2b) begin
                        tests++;
                        if (cyc != last_done_cyc + 1) begin
                            fails++;
                            $display("FAIL back_to_back got grant %0d cycles after done, want 1", cyc - last_done_cyc);
                        end
                    end
                end
            end
            if (active && !load_done && !store_done) begin
                tests++;
                if (!mem_valid) begin
                    fails++; active = 1'b0;
                    $display("FAIL valid_gap got mem_valid=0 before done, want 1");
                end else begin
                    vcnt++;
                    if (mem_write != !cur.op.is_load || mem_address != cur.op.addr ||
                        mem_byte_enable != (cur.op.is_load ? 4'hF : cur.op.be) ||
                        (!cur.op.is_load && mem_write_data != cur.op.wdata)) begin
                        fails++;
                        $display("FAIL mem_fields got wr=%0b addr=%h be=%h wd=%h, want wr=%0b addr=%h be=%h wd=%h",
                                 mem_write, mem_address, mem_byte_enable, mem_write_data, !cur.op.is_load,
                                 cur.op.addr, cur.op.is_load ? 4'hF : cur.op.be, cur.op.wdata);
                    end
                end
            end
            if (load_done || store_done) begin
                tests++;
                if (!active) begin
                    fails++;
                    $display("FAIL unexpected_done got ld=%0b sd=%0b, want none", load_done, store_done);
                end else if (load_done == store_done || load_done != cur.op.is_load || error != cur.err ||
                             mem_valid || vcnt != (cur.err ? TO : cur.op.lat + 1) || load_data != cur.ld) begin
                    fails++;
                    $display("FAIL completion got ld=%0b sd=%0b err=%0b mv=%0b vcyc=%0d ldata=%h, want ld=%0b err=%0b mv=0 vcyc=%0d ldata=%h",
                             load_done, store_done, error, mem_valid, vcnt, load_data, cur.op.is_load, cur.err,
                             cur.err ? TO : cur.op.lat + 1, cur.ld);
                end
                active = 1'b0;
                last_done_cyc = cyc;
                done_seen++;
            end else if (error) begin
                tests++; fails++;
                $display("FAIL error_alone got error=1 without done, want 0");
            end
        end
    end

    initial begin
        int c;
        reset = 1'b1;
        load_request = 1'b0; store_request = 1'b0;
        load_address = '0; store_address = '0; store_data = '0; store_byte_enable = '0;
        repeat (2) @(negedge clock);
        check_zero("reset_state");
        reset = 1'b0;
        @(negedge clock);

        // Minimum-latency load.
        lops.delete(); sops.delete();
        lops.push_back(mk_op(1'b1, 32'h100, '0, 4'hF, 32'hDEADBEEF, 0));
        run_round();
        // Store held for three wait cycles.
        lops.delete(); sops.delete();
        sops.push_back(mk_op(1'b0, 32'h200, 32'h12345678, 4'b0011, '0, 3));
        run_round();
        // Load that never sees mem_ready, then ready exactly on the timeout edge for both sides.
        lops.delete(); sops.delete();
        lops.push_back(mk_op(1'b1, 32'h104, '0, 4'hF, 32'hCAFEF00D, 40));
        run_round();
        lops.delete(); sops.delete();
        lops.push_back(mk_op(1'b1, 32'h203, '0, 4'hF, 32'h0BADF00D, TO - 1));
        sops.push_back(mk_op(1'b0, 32'h301, 32'hA5A5A5A5, 4'b1000, '0, TO - 1));
        run_round();

        // Reset in the second BUSY cycle of a store discards it.
        lops.delete(); sops.delete();
        sops.push_back(mk_op(1'b0, 32'h400, 32'h11112222, 4'b0110, '0, 100));
        model_round();
        store_request = 1'b1; store_address = 32'h400; store_data = 32'h11112222; store_byte_enable = 4'b0110;
        c = 0;
        do begin @(negedge clock); c++; end while (!store_grant && c < 20);
        store_request = 1'b0;
        @(negedge clock);
        tests++;
        if (!mem_valid) begin
            fails++;
            $display("FAIL reset_busy_valid got mem_valid=0 in second BUSY cycle, want 1");
        end
        reset = 1'b1;
        @(negedge clock);
        check_zero("reset_mid_txn");
        @(negedge clock);
        reset = 1'b0;
        model_last_load = 1'b0; model_ld = '0;
        repeat (3) @(negedge clock);
        check_zero("after_reset_idle");

        // Both units requesting continuously: expect L,S,L,S with two-cycle done spacing.
        lops.delete(); sops.delete();
        for (int i = 0; i < 2; i++) begin
            lops.push_back(mk_op(1'b1, 32'h500 + i, '0, 4'hF, $urandom, 0));
            sops.push_back(mk_op(1'b0, 32'h600 + i, $urandom, 4'($urandom), '0, 0));
        end
        run_round();

        // Random traffic.
        for (int r = 0; r < 60; r++) begin
            int nl, ns;
            lops.delete(); sops.delete();
            nl = $urandom_range(0, 2);
            ns = (nl == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
            for (int i = 0; i < nl; i++)
                lops.push_back(mk_op(1'b1, $urandom, '0, 4'hF, $urandom, pick_lat()));
            for (int i = 0; i < ns; i++)
                sops.push_back(mk_op(1'b0, $urandom, $urandom, 4'($urandom), '0, pick_lat()));
            run_round();
        end

        repeat (4) @(negedge clock);
        tests++;
        if (exp_q.size() != 0 || resp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d expected and %0d responses left, want 0", exp_q.size(), resp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
